// File: rtl/ldm_stm_sequencer_pkg.sv
// rtl/ldm_stm_sequencer_pkg.sv - shared types and constants for the register-list sequencer
package ldm_stm_sequencer_pkg;

    typedef enum logic [1:0] {
        UOP_NONE    = 2'd0,
        UOP_LOAD    = 2'd1,
        UOP_STORE   = 2'd2,
        UOP_BASE_WB = 2'd3
    } uop_kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } seq_state_e;

    localparam logic [3:0] SP_ADDR = 4'd13;
    localparam logic [3:0] LR_ADDR = 4'd14;
    localparam logic [3:0] PC_ADDR = 4'd15;

    // A Thumb register list holds at most nine registers, so four bits suffice.
    function automatic logic [3:0] popcount16(input logic [15:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// rtl/ldm_stm_sequencer_if.sv - decode-side handshake and micro-op bus of the sequencer
interface ldm_stm_sequencer_if
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD       = 32
) ();

    logic                  is_valid_i;
    logic [15:0]           instruction_i;
    logic                  hold_i;
    logic                  flush_pipeline_i;
    logic                  stall_fetch_o;
    logic                  uop_valid_o;
    uop_kind_e             uop_kind_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [ADDR_WIDTH-1:0] base_addr_o;
    logic [WORD-1:0]       offset_o;
    logic                  last_uop_o;
    logic                  busy_o;

    modport master (
        output is_valid_i, instruction_i, hold_i, flush_pipeline_i,
        input  stall_fetch_o, uop_valid_o, uop_kind_o, reg_addr_o,
               base_addr_o, offset_o, last_uop_o, busy_o
    );

    modport slave (
        input  is_valid_i, instruction_i, hold_i, flush_pipeline_i,
        output stall_fetch_o, uop_valid_o, uop_kind_o, reg_addr_o,
               base_addr_o, offset_o, last_uop_o, busy_o
    );

endinterface

// File: rtl/ldm_stm_sequencer_reg_list_scanner.sv
// rtl/ldm_stm_sequencer_reg_list_scanner.sv - lowest-set-bit priority encoder over a register mask
module ldm_stm_sequencer_reg_list_scanner (
    input  logic [15:0] mask,
    output logic [3:0]  index,
    output logic [15:0] rest,
    output logic        empty
);

    // Scan downward so the last hit, the lowest set bit, wins.
    always_comb begin
        index = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                index = 4'(i);
            end
        end
        rest  = mask & ~(16'b1 << index);
        empty = ~|mask;
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - PUSH/POP micro-op sequencer; LDMIA/STMIA enabled by LDM_STM_EN
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD       = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    ldm_stm_sequencer_if.slave  bus
);

    seq_state_e            state_q, state_d;
    logic [15:0]           mask_q, mask_d;
    logic [3:0]            k_q, k_d;
    logic [3:0]            n_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  push_q, load_q, skip_wb_q;

    logic                  dec_hit, dec_push, dec_load, dec_skip_wb;
    logic [15:0]           dec_mask;
    logic [ADDR_WIDTH-1:0] dec_base;
    logic [7:0]            dec_list;
    logic                  accept;

    logic [3:0]            scan_idx;
    logic [15:0]           scan_rest;
    logic                  scan_empty;

    always_comb begin
        dec_hit     = 1'b0;
        dec_push    = 1'b0;
        dec_load    = 1'b0;
        dec_skip_wb = 1'b0;
        dec_mask    = '0;
        dec_base    = ADDR_WIDTH'(SP_ADDR);
        dec_list    = bus.instruction_i[7:0];
        if (bus.instruction_i[15:9] == 7'b1011_010) begin
            dec_hit  = 1'b1;
            dec_push = 1'b1;
            dec_mask = {1'b0, bus.instruction_i[8], 6'b0, dec_list};
        end else if (bus.instruction_i[15:9] == 7'b1011_110) begin
            dec_hit  = 1'b1;
            dec_load = 1'b1;
            dec_mask = {bus.instruction_i[8], 7'b0, dec_list};
        end
`ifdef LDM_STM_EN
        else if (bus.instruction_i[15:12] == 4'b1100) begin
            dec_hit     = 1'b1;
            dec_load    = bus.instruction_i[11];
            dec_mask    = {8'b0, dec_list};
            dec_base    = ADDR_WIDTH'(bus.instruction_i[10:8]);
            // Writeback is suppressed when the loaded list already overwrites Rn.
            dec_skip_wb = bus.instruction_i[11] & dec_list[bus.instruction_i[10:8]];
        end
`endif
    end

    assign accept = bus.is_valid_i & (state_q == IDLE) & ~bus.flush_pipeline_i
                  & dec_hit & (|dec_mask);

    ldm_stm_sequencer_reg_list_scanner u_scanner (
        .mask  (mask_q),
        .index (scan_idx),
        .rest  (scan_rest),
        .empty (scan_empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            n_q       <= '0;
            base_q    <= '0;
            push_q    <= 1'b0;
            load_q    <= 1'b0;
            skip_wb_q <= 1'b0;
        end else if (accept) begin
            n_q       <= popcount16(dec_mask);
            base_q    <= dec_base;
            push_q    <= dec_push;
            load_q    <= dec_load;
            skip_wb_q <= dec_skip_wb;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        k_d     = k_q;
        if (bus.flush_pipeline_i) begin
            state_d = IDLE;
            mask_d  = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = XFER;
                        mask_d  = dec_mask;
                        k_d     = '0;
                    end
                end
                XFER: begin
                    if (scan_empty) begin
                        state_d = IDLE;
                    end else if (!bus.hold_i) begin
                        mask_d = scan_rest;
                        k_d    = k_q + 4'd1;
                        if (scan_rest == 16'b0) begin
                            state_d = skip_wb_q ? IDLE : WB;
                        end
                    end
                end
                WB: begin
                    if (!bus.hold_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [WORD-1:0] k4, n4;
    logic            busy, last;

    assign k4   = WORD'({k_q, 2'b00});
    assign n4   = WORD'({n_q, 2'b00});
    assign busy = (state_q != IDLE);

    always_comb begin
        bus.uop_kind_o  = UOP_NONE;
        bus.reg_addr_o  = '0;
        bus.base_addr_o = '0;
        bus.offset_o    = '0;
        last            = 1'b0;
        case (state_q)
            XFER: begin
                bus.uop_kind_o  = load_q ? UOP_LOAD : UOP_STORE;
                bus.reg_addr_o  = ADDR_WIDTH'(scan_idx);
                bus.base_addr_o = base_q;
                bus.offset_o    = push_q ? (k4 - n4) : k4;
                last            = skip_wb_q & (scan_rest == 16'b0);
            end
            WB: begin
                bus.uop_kind_o  = UOP_BASE_WB;
                bus.reg_addr_o  = base_q;
                bus.base_addr_o = base_q;
                bus.offset_o    = push_q ? (WORD'(0) - n4) : n4;
                last            = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.last_uop_o    = last;
    assign bus.busy_o        = busy;
    assign bus.uop_valid_o   = busy & ~bus.flush_pipeline_i;
    assign bus.stall_fetch_o = ~bus.flush_pipeline_i
                             & (accept | (busy & ~last) | (last & bus.hold_i));

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - directed self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;
    import ldm_stm_sequencer_pkg::*;

    logic clk_i;
    logic reset_i;
    int   tests;
    int   fails;

    ldm_stm_sequencer_if #(.ADDR_WIDTH(4), .WORD(32)) bus ();

    ldm_stm_sequencer #(.ADDR_WIDTH(4), .WORD(32)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_uop(input string tag, input logic v, input uop_kind_e kind,
                             input logic [3:0] r, input logic [3:0] b, input logic [31:0] off,
                             input logic last, input logic stall, input logic busy);
        check({tag, ".valid"}, 32'(bus.uop_valid_o), 32'(v));
        check({tag, ".kind"},  32'(bus.uop_kind_o),  32'(kind));
        check({tag, ".reg"},   32'(bus.reg_addr_o),  32'(r));
        check({tag, ".base"},  32'(bus.base_addr_o), 32'(b));
        check({tag, ".off"},   bus.offset_o,         off);
        check({tag, ".last"},  32'(bus.last_uop_o),  32'(last));
        check({tag, ".stall"}, 32'(bus.stall_fetch_o), 32'(stall));
        check({tag, ".busy"},  32'(bus.busy_o),      32'(busy));
    endtask

    task automatic check_idle(input string tag);
        check_uop(tag, 1'b0, UOP_NONE, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input logic v, input logic [15:0] ins, input logic h, input logic f);
        @(posedge clk_i);
        #1;
        bus.is_valid_i       = v;
        bus.instruction_i    = ins;
        bus.hold_i           = h;
        bus.flush_pipeline_i = f;
        @(negedge clk_i);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_i              = 1'b1;
        bus.is_valid_i       = 1'b0;
        bus.instruction_i    = 16'h0;
        bus.hold_i           = 1'b0;
        bus.flush_pipeline_i = 1'b0;
        @(negedge clk_i);
        check_idle("reset");
        @(posedge clk_i);
        #1 reset_i = 1'b0;

        // PUSH {r0,r2,lr}
        cyc(1, 16'hB505, 0, 0);
        check_uop("push.c0", 0, UOP_NONE, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("push.c1", 1, UOP_STORE, 0, 13, 32'hFFFF_FFF4, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("push.c2", 1, UOP_STORE, 2, 13, 32'hFFFF_FFF8, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("push.c3", 1, UOP_STORE, 14, 13, 32'hFFFF_FFFC, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("push.c4", 1, UOP_BASE_WB, 13, 13, 32'hFFFF_FFF4, 1, 0, 1);
        cyc(0, 16'h0, 0, 0);
        check_idle("push.c5");

        // POP {r1,pc}
        cyc(1, 16'hBD02, 0, 0);
        check_uop("pop.c0", 0, UOP_NONE, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("pop.c1", 1, UOP_LOAD, 1, 13, 32'h0, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("pop.c2", 1, UOP_LOAD, 15, 13, 32'h4, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("pop.c3", 1, UOP_BASE_WB, 13, 13, 32'h8, 1, 0, 1);
        cyc(0, 16'h0, 0, 0);
        check_idle("pop.c4");

        // PUSH {r0,r2,lr} with two hold cycles on the second micro-op
        cyc(1, 16'hB505, 0, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("hold.c1", 1, UOP_STORE, 0, 13, 32'hFFFF_FFF4, 0, 1, 1);
        cyc(0, 16'h0, 1, 0);
        check_uop("hold.c2", 1, UOP_STORE, 2, 13, 32'hFFFF_FFF8, 0, 1, 1);
        cyc(0, 16'h0, 1, 0);
        check_uop("hold.c3", 1, UOP_STORE, 2, 13, 32'hFFFF_FFF8, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("hold.c4", 1, UOP_STORE, 2, 13, 32'hFFFF_FFF8, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("hold.c5", 1, UOP_STORE, 14, 13, 32'hFFFF_FFFC, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("hold.c6", 1, UOP_BASE_WB, 13, 13, 32'hFFFF_FFF4, 1, 0, 1);
        cyc(0, 16'h0, 0, 0);
        check_idle("hold.c7");

        // POP {r0-r7} flushed in cycle 2
        cyc(1, 16'hBCFF, 0, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("flush.c1", 1, UOP_LOAD, 0, 13, 32'h0, 0, 1, 1);
        cyc(0, 16'h0, 0, 1);
        check("flush.c2.valid", 32'(bus.uop_valid_o), 32'd0);
        check("flush.c2.stall", 32'(bus.stall_fetch_o), 32'd0);
        cyc(0, 16'h0, 0, 0);
        check_idle("flush.c3");
        cyc(0, 16'h0, 0, 0);
        check_idle("flush.c4");

        // Asynchronous reset in the middle of a PUSH
        cyc(1, 16'hB505, 0, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("rst.c1", 1, UOP_STORE, 0, 13, 32'hFFFF_FFF4, 0, 1, 1);
        #2 reset_i = 1'b1;
        #1;
        check_idle("rst.async");
        #1 reset_i = 1'b0;

        // PUSH {r0}: hold in the accept cycle and on the writeback
        cyc(1, 16'hB401, 1, 0);
        check_uop("push1.c0", 0, UOP_NONE, 0, 0, 32'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 0);
        check_uop("push1.c1", 1, UOP_STORE, 0, 13, 32'hFFFF_FFFC, 0, 1, 1);
        cyc(0, 16'h0, 1, 0);
        check_uop("push1.c2", 1, UOP_BASE_WB, 13, 13, 32'hFFFF_FFFC, 1, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("push1.c3", 1, UOP_BASE_WB, 13, 13, 32'hFFFF_FFFC, 1, 0, 1);
        cyc(0, 16'h0, 0, 0);
        check_idle("push1.c4");

        // Empty PUSH list is not accepted
        cyc(1, 16'hB400, 0, 0);
        check("empty.c0.stall", 32'(bus.stall_fetch_o), 32'd0);
        cyc(0, 16'h0, 0, 0);
        check_idle("empty.c1");

`ifdef LDM_STM_EN
        // LDMIA r1!,{r1,r2}: base in list, no writeback
        cyc(1, 16'hC906, 0, 0);
        check("ldm.c0.stall", 32'(bus.stall_fetch_o), 32'd1);
        cyc(0, 16'h0, 0, 0);
        check_uop("ldm.c1", 1, UOP_LOAD, 1, 1, 32'h0, 0, 1, 1);
        cyc(0, 16'h0, 0, 0);
        check_uop("ldm.c2", 1, UOP_LOAD, 2, 1, 32'h4, 1, 0, 1);
        cyc(0, 16'h0, 0, 0);
        check_idle("ldm.c3");
`else
        // LDMIA encoding is ignored without the multiple-transfer feature
        cyc(1, 16'hC906, 0, 0);
        check("ldm_off.c0.stall", 32'(bus.stall_fetch_o), 32'd0);
        cyc(0, 16'h0, 0, 0);
        check_idle("ldm_off.c1");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for Thumb register-list instructions (PUSH, POP, and optionally LDMIA/STMIA) in the decode stage. It latches the register list of an accepted instruction and emits one micro-op per cycle to the decode datapath: register address, signed address offset, and load/store kind, followed by a base-register writeback micro-op. While a sequence is running it stalls fetch so the instruction in decode stays put. It holds on downstream hazard stalls and aborts on pipeline flush.

## Interface
- ADDR_WIDTH, 4, register address width
- WORD, 32, data/offset width
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- is_valid_i  in  1  instruction_i is valid this cycle
- instruction_i  in  16  Thumb instruction currently in decode
- hold_i  in  1  hazard stall from decode; freeze current micro-op
- flush_pipeline_i  in  1  abort any sequence
- stall_fetch_o  out  1  hold fetch/decode input register
- uop_valid_o  out  1  micro-op outputs are meaningful
- uop_kind_o  out  uop_kind_e  UOP_NONE / UOP_LOAD / UOP_STORE / UOP_BASE_WB
- reg_addr_o  out  ADDR_WIDTH  transfer register (LOAD/STORE) or base register (BASE_WB)
- base_addr_o  out  ADDR_WIDTH  base register: SP (13) for PUSH/POP, Rn for LDM/STM
- offset_o  out  WORD  signed byte offset from base (two's complement)
- last_uop_o  out  1  current micro-op is the final one
- busy_o  out  1  sequencer is not in IDLE

## Operation
- Decode (only when is_valid_i, in IDLE, no flush): PUSH 1011_010R_llllllll, so the list is l plus LR if R. POP 1011_110P_llllllll, so the list is l plus PC if P. STMIA 11000_nnn_llllllll, LDMIA 11001_nnn_llllllll (macro-gated). Any other encoding is ignored.
- Empty list (list bits all zero, R/P zero): not accepted. No stall, no micro-ops.
- Accept cycle: latch the list as a 16-bit mask, N = popcount (1..9), base, and kind. Assert stall_fetch_o combinationally. Go to XFER.
- XFER: each cycle present the lowest set mask bit as reg_addr_o, then clear it and increment k (0..N-1) when not hold_i.
  - PUSH/STM: kind STORE.
  - POP/LDM: kind LOAD.
  - Offset for PUSH: -4N + 4k.
  - Offset for POP/LDM/STM: +4k.
- When the mask empties, go to WB. Present BASE_WB with reg_addr_o = base and last_uop_o = 1.
  - Offset for PUSH: -4N.
  - Offset for all other kinds: +4N.
- LDMIA with Rn in the list: no WB. The last XFER micro-op carries last_uop_o and the FSM returns to IDLE.
- Offset arithmetic: 4N fits in 6 bits, zero-extended then negated/sign-extended to WORD. No overflow is possible.
- stall_fetch_o = accept | (busy_o & ~last_uop_o) | (last_uop_o & hold_i).
- uop_valid_o = busy_o & ~flush_pipeline_i.
- Outputs when idle: uop_valid_o, uop_kind_o = UOP_NONE, reg_addr_o, base_addr_o, offset_o, last_uop_o, busy_o and stall_fetch_o all 0.

## Timing
- Reset (asynchronous): FSM in IDLE, mask/counter 0, all outputs 0 as listed above. Reset mid-sequence drops it entirely.
- Latency: micro-op 0 appears the cycle after acceptance. A sequence with N transfers plus WB lasts N+1 cycles without holds.
- hold_i: all registered state and outputs stay frozen that cycle. Holding in the accept cycle does not delay latching.
- flush_pipeline_i: forces IDLE at the next edge. uop_valid_o and stall_fetch_o are 0 in the flush cycle. Flush has priority over hold and accept.
- Return to IDLE after the last micro-op (not held). The next instruction may be accepted in the first IDLE cycle.

## Configuration
- LDM_STM_EN defined: LDMIA/STMIA decoded and sequenced as above, with base = Rn (0..7).
- LDM_STM_EN undefined: only PUSH/POP are recognised; 11000/11001 encodings are ignored (no accept, no stall). Base is the constant 13.

## Structure
- Add to the shared GENERAL_DEFS package:
  - typedef uop_kind_e
  - typedef seq_state_e (IDLE, XFER, WB)
  - constants SP_ADDR = 13, LR_ADDR = 14, PC_ADDR = 15
- One sub-module, reg_list_scanner: combinational lowest-set-bit priority encoder over the 16-bit mask. Outputs the index, the mask with that bit cleared, and an empty flag.

## Test plan
- PUSH {r0,r2,lr} (0xB505):
  - Cycles 1–3: STORE r0/-12, r2/-8, r14/-4.
  - Cycle 4: BASE_WB r13/-12 with last_uop_o.
  - stall_fetch_o is high for cycles 0–3.
- POP {r1,pc} (0xBD02): LOAD r1/+0, LOAD r15/+4, BASE_WB r13/+8.
- hold_i held for 2 cycles during the second micro-op of the PUSH above: r2/-8 repeats for 3 cycles, the sequence stretches to 6 cycles, and offsets are unchanged.
- flush_pipeline_i in cycle 2 of POP {r0-r7} (0xBCFF): uop_valid_o goes to 0 that cycle, IDLE follows, and no WB is emitted.
- reset_i asserted mid-sequence (asynchronously, between edges): all outputs go to 0 immediately. A following 0xB401 (PUSH {r0}) runs cleanly as STORE r0/-4, then WB r13/-4.
- 0xB400 (empty list) produces no accept and no stall. With LDM_STM_EN, 0xC906 (LDMIA r1!,{r1,r2}) gives LOAD r1/+0, then LOAD r2/+4 with last_uop_o, and no WB.
